mc_rfr_ctrl: RTL and testbench
==============================

MC_RFR_CTRL -- requirements
Module: mc_rfr_ctrl

Interface
REQ-001 SHALL have parameter RFR_PEND_MAX, default 4; maximum refreshes held pending (burst depth), range 2..7.
REQ-002 SHALL have parameter RFR_INT_W, default 8; width of the refresh interval field.
REQ-003 SHALL have port clk, input, 1; the single clock of the block, the memory-controller core clock.
REQ-004 SHALL have port rst_, input, 1; reset, asynchronous and active-low.
REQ-005 SHALL have port rfr_en, input, 1; global refresh enable.
REQ-006 SHALL have port cs_rfr_en, input, 8; per chip-select flag marking an SDRAM bank that needs refresh.
REQ-007 SHALL have port rfr_ps_sel, input, 3; prescaler select; tick period is (16 << rfr_ps_sel) clocks.
REQ-008 SHALL have port rfr_int, input, RFR_INT_W; a refresh is due every rfr_int+1 ticks.
REQ-009 SHALL have port rfr_trc, input, 4; post-refresh guard time, in clocks.
REQ-010 SHALL have port rfr_ack, input, 1; one-cycle pulse from the main FSM when a refresh is issued to the memory interface.
REQ-011 SHALL have port rfr_req, output, 1; refresh request to the main FSM.
REQ-012 SHALL have port cs_need_rfr, output, 8; chip selects to refresh; feeds the chip-select mux of the memory interface.
REQ-013 SHALL have port rfr_pend, output, 3; current pending refresh count.
REQ-014 SHALL have port rfr_ovf, output, 1; sticky flag set when a refresh is lost.

Function
REQ-015 SHALL run a prescaler counting clk; it SHALL emit a one-cycle tick when the count reaches (16 << rfr_ps_sel)-1, then wrap to 0.
REQ-016 SHALL run an interval counter that advances on each tick; when it reaches rfr_int on a tick, it SHALL wrap to 0 and assert a one-cycle "due" pulse.
REQ-017 On "due" with no rfr_ack in the same cycle, SHALL increment rfr_pend, saturating at RFR_PEND_MAX.
REQ-018 On "due" when rfr_pend already equals RFR_PEND_MAX, SHALL leave rfr_pend unchanged and set rfr_ovf.
REQ-019 On rfr_ack without "due" in the same cycle, SHALL decrement rfr_pend; rfr_ack with rfr_pend=0 SHALL be ignored.
REQ-020 When "due" and rfr_ack occur in the same cycle, SHALL leave rfr_pend unchanged and SHALL NOT set rfr_ovf.
REQ-021 SHALL implement FSM IDLE, REQ, GUARD:
  - IDLE -> REQ when rfr_pend>0 and cs_rfr_en!=0.
  - REQ -> GUARD on rfr_ack.
  - GUARD: count rfr_trc clocks, then go to REQ if rfr_pend>0 (value after the ack decrement), else to IDLE.
  - rfr_trc=0 SHALL give a single GUARD cycle.
REQ-022 rfr_req SHALL be registered and high exactly while the FSM is in REQ; it SHALL rise one clock after the transition condition.
REQ-023 cs_need_rfr SHALL capture cs_rfr_en on entry to REQ and hold stable through REQ and GUARD; it SHALL be 0 in IDLE.
REQ-024 rfr_en low SHALL synchronously clear the prescaler, interval counter and rfr_pend, and force the FSM to IDLE; rfr_ovf SHALL be kept.
REQ-025 Changes to rfr_ps_sel or rfr_int SHALL take effect at the next wrap; a count already above a new, smaller terminal value SHALL wrap at the counter's natural overflow.
REQ-026 rfr_ovf SHALL be cleared only by reset.

Reset
REQ-027 rst_ low SHALL asynchronously force: rfr_req=0, cs_need_rfr=8'h00, rfr_pend=0, rfr_ovf=0, FSM=IDLE, all counters=0.
REQ-028 Reset asserted mid-REQ SHALL drop rfr_req immediately; after release, the first request SHALL need a full interval.

Configuration
REQ-029 Macro MC_RFR_BURST_EN defined: pending counter as specified, depth RFR_PEND_MAX.
REQ-030 Macro MC_RFR_BURST_EN undefined: rfr_pend SHALL be a single bit (max 1, upper bits tied 0), and a "due" while pending SHALL set rfr_ovf.

Structure
REQ-031 The FSM state encoding, the prescaler base constant 16 and the RFR_PEND_MAX default SHALL live in the shared mc_defines package/include.
REQ-032 The prescaler plus interval counter SHALL be one sub-module, mc_rfr_timer, with outputs tick and due.

Verification
REQ-033 rfr_ps_sel=0, rfr_int=1, cs_rfr_en=8'h01, ack 3 clocks after each req -> rfr_req rises every 32 clocks, cs_need_rfr=8'h01.
REQ-034 No ack, 5 "due" pulses, burst build -> rfr_pend=4 after the 4th, rfr_ovf=1 after the 5th; 4 acks return rfr_pend to 0.
REQ-035 rfr_ack forced in the same cycle as "due" with rfr_pend=2 -> rfr_pend stays 2, rfr_ovf stays 0.
REQ-036 rfr_trc=5, rfr_pend=2, ack -> rfr_req low for exactly 6 clocks, then high again.
REQ-037 rst_ low while rfr_req=1 -> rfr_req=0 and cs_need_rfr=0 with no clock edge; after release, no request before 32 clocks (ps_sel=0, int=1).
REQ-038 MC_RFR_BURST_EN undefined, two "due" pulses with no ack -> rfr_pend=1, rfr_ovf=1.

Source files
------------

// File: rtl/mc_defines_pkg.sv
// mc_defines: shared memory-controller constants, refresh FSM encoding and prescaler helper
// Contents:
//   RFR_PS_BASE       prescaler base period in clocks (tick period = RFR_PS_BASE << ps_sel)
//   RFR_PS_W          prescaler counter width (covers RFR_PS_BASE << 7)
//   RFR_PEND_MAX_DEF  default refresh burst depth
//   rfr_st_e          refresh FSM state encoding
//   rfr_ps_term()     prescaler terminal count for a given prescaler select
package mc_defines;

    localparam int RFR_PS_BASE      = 16;
    localparam int RFR_PS_W         = 11;
    localparam int RFR_PEND_MAX_DEF = 4;

    typedef enum logic [1:0] {
        RFR_IDLE  = 2'd0,
        RFR_REQ   = 2'd1,
        RFR_GUARD = 2'd2
    } rfr_st_e;

    function automatic logic [RFR_PS_W-1:0] rfr_ps_term(input logic [2:0] sel);
        return RFR_PS_W'((RFR_PS_BASE << sel) - 1);
    endfunction

endpackage

// File: rtl/mc_rfr_timer.sv
// mc_rfr_timer: refresh prescaler plus interval counter producing tick and due pulses
// Ports:
//   clk      core clock
//   rst_     asynchronous active-low reset
//   en       refresh enable; low holds both counters at zero
//   ps_sel   prescaler select, tick period is (16 << ps_sel) clocks
//   int_val  a due pulse is produced every int_val+1 ticks
//   tick     one-cycle prescaler wrap pulse
//   due      one-cycle refresh-due pulse
module mc_rfr_timer
    import mc_defines::*;
#(
    parameter int RFR_INT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 en,
    input  logic [2:0]           ps_sel,
    input  logic [RFR_INT_W-1:0] int_val,
    output logic                 tick,
    output logic                 due
);

    logic [RFR_PS_W-1:0]  ps_cnt;
    logic [RFR_INT_W-1:0] int_cnt;

    // Equality compares only: a count left above a freshly lowered terminal
    // value runs on to the natural counter overflow before wrapping.
    assign tick = en && ps_cnt == rfr_ps_term(ps_sel);
    assign due  = tick && int_cnt == int_val;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ps_cnt  <= '0;
            int_cnt <= '0;
        end else begin
            ps_cnt  <= (!en || tick) ? '0 : ps_cnt + 1'b1;
            int_cnt <= (!en || due) ? '0 : tick ? int_cnt + 1'b1 : int_cnt;
        end
    end

endmodule

// File: rtl/mc_rfr_ctrl.sv
// mc_rfr_ctrl: SDRAM refresh scheduler with pending-refresh burst counter and request FSM
// Ports:
//   clk          core clock
//   rst_         asynchronous active-low reset
//   rfr_en       global refresh enable; low clears timers, pending count and FSM (rfr_ovf kept)
//   cs_rfr_en    chip selects needing refresh
//   rfr_ps_sel   prescaler select, tick period (16 << rfr_ps_sel) clocks
//   rfr_int      refresh due every rfr_int+1 ticks
//   rfr_trc      post-refresh guard time in clocks (GUARD lasts rfr_trc+1 cycles)
//   rfr_ack      refresh issued by the main FSM
//   rfr_req      refresh request, high while in REQ
//   cs_need_rfr  chip selects captured on entry to REQ, zero in IDLE
//   rfr_pend     pending refresh count
//   rfr_ovf      sticky lost-refresh flag, cleared only by reset
// Build option:
//   MC_RFR_BURST_EN defined: pending counter up to RFR_PEND_MAX;
//   undefined: single pending refresh, a due while pending sets rfr_ovf.
module mc_rfr_ctrl
    import mc_defines::*;
#(
    parameter int RFR_PEND_MAX = RFR_PEND_MAX_DEF,
    parameter int RFR_INT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 rfr_en,
    input  logic [7:0]           cs_rfr_en,
    input  logic [2:0]           rfr_ps_sel,
    input  logic [RFR_INT_W-1:0] rfr_int,
    input  logic [3:0]           rfr_trc,
    input  logic                 rfr_ack,
    output logic                 rfr_req,
    output logic [7:0]           cs_need_rfr,
    output logic [2:0]           rfr_pend,
    output logic                 rfr_ovf
);

`ifdef MC_RFR_BURST_EN
    localparam int            PW  = 3;
    localparam logic [PW-1:0] LIM = PW'(RFR_PEND_MAX);
`else
    localparam int            PW  = 1;
    localparam logic [PW-1:0] LIM = 1'b1;
`endif

    if (RFR_PEND_MAX < 2 || RFR_PEND_MAX > 7) begin : g_pend_range
        $error("RFR_PEND_MAX must be in 2..7");
    end

    logic          due;
    logic          tick_unused;
    logic [PW-1:0] pend;
    logic [3:0]    g_cnt;
    rfr_st_e       st, st_nxt;

    mc_rfr_timer #(
        .RFR_INT_W(RFR_INT_W)
    ) u_timer (
        .clk    (clk),
        .rst_   (rst_),
        .en     (rfr_en),
        .ps_sel (rfr_ps_sel),
        .int_val(rfr_int),
        .tick   (tick_unused),
        .due    (due)
    );

    assign rfr_pend = 3'(pend);

    // A due and an ack in the same cycle cancel: count unchanged, no overflow.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pend    <= '0;
            rfr_ovf <= 1'b0;
        end else begin
            pend    <= !rfr_en ? '0 :
                       (due && !rfr_ack && pend != LIM) ? pend + 1'b1 :
                       (rfr_ack && !due && pend != '0) ? pend - 1'b1 : pend;
            rfr_ovf <= rfr_ovf || (due && !rfr_ack && pend == LIM);
        end
    end

    // GUARD exit looks at the registered count, which already reflects the ack.
    always_comb begin
        st_nxt = st;
        case (st)
            RFR_IDLE:  if (pend != '0 && cs_rfr_en != '0) st_nxt = RFR_REQ;
            RFR_REQ:   if (rfr_ack) st_nxt = RFR_GUARD;
            RFR_GUARD: if (g_cnt == rfr_trc) st_nxt = (pend != '0) ? RFR_REQ : RFR_IDLE;
            default:   st_nxt = RFR_IDLE;
        endcase
        if (!rfr_en) st_nxt = RFR_IDLE;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            st          <= RFR_IDLE;
            g_cnt       <= '0;
            rfr_req     <= 1'b0;
            cs_need_rfr <= '0;
        end else begin
            st          <= st_nxt;
            g_cnt       <= (st == RFR_GUARD && st_nxt == RFR_GUARD) ? g_cnt + 1'b1 : '0;
            rfr_req     <= st_nxt == RFR_REQ;
            cs_need_rfr <= (st_nxt == RFR_IDLE) ? '0 :
                           (st != RFR_REQ && st_nxt == RFR_REQ) ? cs_rfr_en : cs_need_rfr;
        end
    end

endmodule

// File: tb/tb_mc_rfr_ctrl.sv
// tb_mc_rfr_ctrl: directed and randomized bench for mc_rfr_ctrl against a behavioural model
module tb_mc_rfr_ctrl;

    localparam int PMAX = 4;
`ifdef MC_RFR_BURST_EN
    localparam int LIM = PMAX;
`else
    localparam int LIM = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       rfr_en = 1'b0;
    logic [7:0] cs_rfr_en = '0;
    logic [2:0] rfr_ps_sel = '0;
    logic [7:0] rfr_int = '0;
    logic [3:0] rfr_trc = '0;
    logic       rfr_ack = 1'b0;
    logic       rfr_req;
    logic [7:0] cs_need_rfr;
    logic [2:0] rfr_pend;
    logic       rfr_ovf;

    int total = 0;
    int bad = 0;

    // model: enabled-edge count, pending count, phase 0 idle / 1 req / 2 guard
    int         m_n, m_pend, m_ph, m_g, m_cyc;
    bit         m_ovf;
    logic [7:0] m_cs;

    always #5 clk = ~clk;

    mc_rfr_ctrl #(.RFR_PEND_MAX(PMAX), .RFR_INT_W(8)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .rfr_en     (rfr_en),
        .cs_rfr_en  (cs_rfr_en),
        .rfr_ps_sel (rfr_ps_sel),
        .rfr_int    (rfr_int),
        .rfr_trc    (rfr_trc),
        .rfr_ack    (rfr_ack),
        .rfr_req    (rfr_req),
        .cs_need_rfr(cs_need_rfr),
        .rfr_pend   (rfr_pend),
        .rfr_ovf    (rfr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit m_due_at(input int n);
        int per;
        per = (16 << rfr_ps_sel) * (int'(rfr_int) + 1);
        return n != 0 && n % per == 0;
    endfunction

    task automatic m_reset();
        m_n = 0; m_pend = 0; m_ph = 0; m_g = 0; m_ovf = 0; m_cs = '0;
    endtask

    task automatic model_edge();
        int old;
        bit due;
        old = m_pend;
        if (!rfr_en) begin
            m_n = 0; m_pend = 0; m_ph = 0; m_cs = '0;
            return;
        end
        m_n++;
        due = m_due_at(m_n);
        case (m_ph)
            0: if (old > 0 && cs_rfr_en != 0) begin m_ph = 1; m_cs = cs_rfr_en; end
            1: if (rfr_ack) begin m_ph = 2; m_g = rfr_trc; end
            default: begin
                if (m_g != 0) m_g--;
                else if (old > 0) begin m_ph = 1; m_cs = cs_rfr_en; end
                else begin m_ph = 0; m_cs = '0; end
            end
        endcase
        if (due && !rfr_ack) begin
            if (old == LIM) m_ovf = 1;
            else m_pend = old + 1;
        end else if (rfr_ack && !due && old > 0) m_pend = old - 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        m_cyc++;
        @(negedge clk);
        chk("req", rfr_req, m_ph == 1);
        chk("cs", cs_need_rfr, m_cs);
        chk("pend", rfr_pend, m_pend);
        chk("ovf", rfr_ovf, m_ovf);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        rfr_ack = 1'b0;
        #1;
        m_reset();
        chk("rst_req", rfr_req, 0);
        chk("rst_cs", cs_need_rfr, 0);
        chk("rst_pend", rfr_pend, 0);
        chk("rst_ovf", rfr_ovf, 0);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    // mode 0: no ack, 1: ack on the 3rd clock of each request, 2: random traffic
    task automatic run(input int n, input int mode, input int per);
        int   age;
        int   last;
        logic prev;
        age = 0;
        last = -1;
        prev = rfr_req;
        for (int i = 0; i < n; i++) begin
            age = (m_ph == 1) ? age + 1 : 0;
            case (mode)
                1: rfr_ack = (age == 3);
                2: begin
                    rfr_ack = (m_ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
                    rfr_en = ($urandom_range(0, 499) != 0);
                    if ($urandom_range(0, 63) == 0) cs_rfr_en = 8'($urandom);
                end
                default: rfr_ack = 1'b0;
            endcase
            step();
            if (per != 0 && rfr_req && !prev) begin
                if (last >= 0) chk("period", m_cyc - last, per);
                last = m_cyc;
            end
            prev = rfr_req;
        end
        rfr_ack = 1'b0;
    endtask

    initial begin
        int lo;
        int k;
        m_cyc = 0;
        do_reset();

        // periodic request with ack three clocks in
        rfr_en = 1'b1; rfr_ps_sel = 3'd0; rfr_int = 8'd1; cs_rfr_en = 8'h01; rfr_trc = 4'd0;
        run(200, 1, 32);

        // burst build-up, overflow, drain
        do_reset();
        cs_rfr_en = 8'h00;
        run(128, 0, 0);
        chk("burst_pend", rfr_pend, LIM);
        chk("burst_ovf4", rfr_ovf, LIM < 4);
        run(32, 0, 0);
        chk("burst_ovf5", rfr_ovf, 1);
        repeat (4) begin
            rfr_ack = 1'b1; step();
            rfr_ack = 1'b0; step();
        end
        chk("drain_pend", rfr_pend, 0);

        // ack colliding with due
        do_reset();
        run(LIM >= 2 ? 64 : 32, 0, 0);
        k = 0;
        while (!m_due_at(m_n + 1) && k < 200) begin step(); k++; end
        rfr_ack = 1'b1; step(); rfr_ack = 1'b0;
        chk("coll_pend", rfr_pend, LIM >= 2 ? 2 : 1);
        chk("coll_ovf", rfr_ovf, 0);

        // guard time rfr_trc=5 gives six low clocks before re-request
        do_reset();
        cs_rfr_en = 8'h01; rfr_trc = 4'd5;
        run(61, 0, 0);
        rfr_ack = 1'b1; step(); rfr_ack = 1'b0;
        lo = 0;
        while (!rfr_req && lo < 50) begin lo++; step(); end
        chk("guard_low", lo, 6);

        // asynchronous reset in the middle of a request
        do_reset();
        rfr_trc = 4'd0;
        run(40, 0, 0);
        chk("pre_rst_req", rfr_req, 1);
        rst_ = 1'b0;
        #1;
        chk("async_req", rfr_req, 0);
        chk("async_cs", cs_need_rfr, 0);
        m_reset();
        @(negedge clk);
        rst_ = 1'b1;
        k = 0;
        while (!rfr_req && k < 100) begin step(); k++; end
        chk("first_req", k, 33);

        // randomized configurations, reconfigured only while disabled
        for (int r = 0; r < 9; r++) begin
            rfr_en = 1'b0;
            step(); step();
            rfr_ps_sel = (r == 8) ? 3'd7 : 3'($urandom_range(0, 2));
            rfr_int = (r == 8) ? 8'd0 : 8'($urandom_range(0, 3));
            rfr_trc = 4'($urandom_range(0, 15));
            cs_rfr_en = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rfr_en = 1'b1;
            run(r == 8 ? 4200 : 1500, 2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
